// File: rtl/m_wbuart.sv
// m_wbuart: Wishbone-attached 8N1 UART with one-byte transmit holding register
// and one-byte receive register.
//
// Ports:
//   CLK_I    system clock
//   RST_I    asynchronous, active-low reset
//   STB_I    bus strobe, already address-qualified
//   WE_I     write enable
//   ADR_I    0 = data register, 1 = status/control register
//   DAT_I    write data (8 bits)
//   DAT_O    read data, zero whenever STB_I is low (OR-able onto the bus)
//   ACK_O    acknowledge, equal to STB_I (zero wait states)
//   usartRX  asynchronous serial input
//   usartTX  registered serial output
//
// Status read layout: {28'b0, ferr, ovr, rxvalid, txfull|txbusy}.
// Control write: DAT_I[2] clears ovr, DAT_I[3] clears ferr.
module m_wbuart #(
    parameter int unsigned DIVISOR = 104
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic        STB_I,
    input  logic        WE_I,
    input  logic        ADR_I,
    input  logic [7:0]  DAT_I,
    output logic [31:0] DAT_O,
    output logic        ACK_O,
    input  logic        usartRX,
    output logic        usartTX
);

    localparam int unsigned CNT_W = 16;
    localparam int unsigned BIT_W = 3;
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(DIVISOR - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(DIVISOR / 2 - 1);
    localparam logic [BIT_W-1:0] BIT_MSB   = BIT_W'(7);

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic w_rd_data;
    logic w_wr_data;
    logic w_wr_ctrl;

    assign w_rd_data = STB_I & ~WE_I & ~ADR_I;
    assign w_wr_data = STB_I &  WE_I & ~ADR_I;
    assign w_wr_ctrl = STB_I &  WE_I &  ADR_I;

    // ------------------------------------------------------------------
    // Transmit path
    // ------------------------------------------------------------------
    tx_state_t        r_tx_state;
    tx_state_t        w_tx_state_nxt;
    logic [CNT_W-1:0] r_tx_cnt;
    logic [CNT_W-1:0] w_tx_cnt_nxt;
    logic [BIT_W-1:0] r_tx_bit;
    logic [BIT_W-1:0] w_tx_bit_nxt;
    logic [7:0]       r_tx_shift;
    logic [7:0]       w_tx_shift_nxt;
    logic             r_tx_out;
    logic             w_tx_out_nxt;
    logic             w_tx_load;
    logic             w_tx_tick;
    logic [7:0]       r_txhold;
    logic             r_txfull;
    logic             w_txbusy;

    assign w_tx_tick = (r_tx_cnt == BIT_LAST);
    assign w_txbusy  = (r_tx_state != TX_IDLE);
    assign usartTX   = r_tx_out;

    // TX state register
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_tx_out   <= 1'b1;
        end else begin
            r_tx_state <= w_tx_state_nxt;
            r_tx_cnt   <= w_tx_cnt_nxt;
            r_tx_bit   <= w_tx_bit_nxt;
            r_tx_shift <= w_tx_shift_nxt;
            r_tx_out   <= w_tx_out_nxt;
        end
    end

    // TX next-state: every state lasts DIVISOR cycles; STOP chains straight
    // into START when another byte is already waiting.
    always_comb begin
        w_tx_state_nxt = r_tx_state;
        w_tx_cnt_nxt   = r_tx_cnt + CNT_W'(1);
        w_tx_bit_nxt   = r_tx_bit;
        w_tx_shift_nxt = r_tx_shift;
        w_tx_out_nxt   = r_tx_out;
        w_tx_load      = 1'b0;
        case (r_tx_state)
            TX_IDLE: begin
                w_tx_cnt_nxt = '0;
                w_tx_bit_nxt = '0;
                w_tx_out_nxt = 1'b1;
                if (r_txfull) begin
                    w_tx_load      = 1'b1;
                    w_tx_shift_nxt = r_txhold;
                    w_tx_out_nxt   = 1'b0;
                    w_tx_state_nxt = TX_START;
                end
            end
            TX_START: begin
                if (w_tx_tick) begin
                    w_tx_cnt_nxt   = '0;
                    w_tx_bit_nxt   = '0;
                    w_tx_out_nxt   = r_tx_shift[0];
                    w_tx_state_nxt = TX_DATA;
                end
            end
            TX_DATA: begin
                if (w_tx_tick) begin
                    w_tx_cnt_nxt = '0;
                    if (r_tx_bit == BIT_MSB) begin
                        w_tx_out_nxt   = 1'b1;
                        w_tx_state_nxt = TX_STOP;
                    end else begin
                        w_tx_bit_nxt   = r_tx_bit + BIT_W'(1);
                        w_tx_shift_nxt = {1'b0, r_tx_shift[7:1]};
                        w_tx_out_nxt   = r_tx_shift[1];
                    end
                end
            end
            TX_STOP: begin
                if (w_tx_tick) begin
                    w_tx_cnt_nxt = '0;
                    if (r_txfull) begin
                        w_tx_load      = 1'b1;
                        w_tx_shift_nxt = r_txhold;
                        w_tx_out_nxt   = 1'b0;
                        w_tx_state_nxt = TX_START;
                    end else begin
                        w_tx_state_nxt = TX_IDLE;
                    end
                end
            end
            default: begin
                w_tx_cnt_nxt   = '0;
                w_tx_out_nxt   = 1'b1;
                w_tx_state_nxt = TX_IDLE;
            end
        endcase
    end

    // Holding register: a write while full is dropped, so a write and a
    // load can never collide in the same cycle.
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            r_txhold <= '0;
            r_txfull <= 1'b0;
        end else if (w_wr_data && !r_txfull) begin
            r_txhold <= DAT_I;
            r_txfull <= 1'b1;
        end else if (w_tx_load) begin
            r_txfull <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Receive path
    // ------------------------------------------------------------------
    logic             r_rx_meta;
    logic             r_rx_sync;
    rx_state_t        r_rx_state;
    rx_state_t        w_rx_state_nxt;
    logic [CNT_W-1:0] r_rx_cnt;
    logic [CNT_W-1:0] w_rx_cnt_nxt;
    logic [BIT_W-1:0] r_rx_bit;
    logic [BIT_W-1:0] w_rx_bit_nxt;
    logic [7:0]       r_rx_shift;
    logic [7:0]       w_rx_shift_nxt;
    logic             w_rx_done;
    logic             w_rx_tick;
    logic [7:0]       r_rxdata;
    logic             r_rxvalid;
    logic             r_ovr;
    logic             r_ferr;

    assign w_rx_tick = (r_rx_cnt == '0);

    // Two-flop synchroniser; idles high so reset does not look like a start bit
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= usartRX;
            r_rx_sync <= r_rx_meta;
        end
    end

    // RX state register
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            r_rx_state <= RX_IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
        end else begin
            r_rx_state <= w_rx_state_nxt;
            r_rx_cnt   <= w_rx_cnt_nxt;
            r_rx_bit   <= w_rx_bit_nxt;
            r_rx_shift <= w_rx_shift_nxt;
        end
    end

    // RX next-state: a down-counter preloaded for half a bit from IDLE puts
    // every later sample near the middle of its bit.
    always_comb begin
        w_rx_state_nxt = r_rx_state;
        w_rx_cnt_nxt   = r_rx_cnt - CNT_W'(1);
        w_rx_bit_nxt   = r_rx_bit;
        w_rx_shift_nxt = r_rx_shift;
        w_rx_done      = 1'b0;
        case (r_rx_state)
            RX_IDLE: begin
                w_rx_cnt_nxt = HALF_LAST;
                w_rx_bit_nxt = '0;
                if (!r_rx_sync) begin
                    w_rx_state_nxt = RX_START;
                end
            end
            RX_START: begin
                if (w_rx_tick) begin
                    w_rx_cnt_nxt   = BIT_LAST;
                    // line back high at mid-start: glitch, not a frame
                    w_rx_state_nxt = r_rx_sync ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (w_rx_tick) begin
                    w_rx_cnt_nxt   = BIT_LAST;
                    w_rx_shift_nxt = {r_rx_sync, r_rx_shift[7:1]};
                    w_rx_bit_nxt   = r_rx_bit + BIT_W'(1);
                    if (r_rx_bit == BIT_MSB) begin
                        w_rx_state_nxt = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (w_rx_tick) begin
                    w_rx_done      = 1'b1;
                    w_rx_state_nxt = RX_IDLE;
                end
            end
            default: begin
                w_rx_state_nxt = RX_IDLE;
            end
        endcase
    end

    // Receive register and flags; a completing byte beats a clear request,
    // and a read accepted in the completion cycle suppresses the overrun.
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            r_rxdata  <= '0;
            r_rxvalid <= 1'b0;
            r_ovr     <= 1'b0;
            r_ferr    <= 1'b0;
        end else begin
            if (w_rx_done) begin
                r_rxdata  <= r_rx_shift;
                r_rxvalid <= 1'b1;
            end else if (w_rd_data) begin
                r_rxvalid <= 1'b0;
            end

            if (w_rx_done && r_rxvalid && !w_rd_data) begin
                r_ovr <= 1'b1;
            end else if (w_wr_ctrl && DAT_I[2]) begin
                r_ovr <= 1'b0;
            end

            if (w_rx_done && !r_rx_sync) begin
                r_ferr <= 1'b1;
            end else if (w_wr_ctrl && DAT_I[3]) begin
                r_ferr <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read mux, gated by the strobe so it can be ORed onto the shared bus
    // ------------------------------------------------------------------
    always_comb begin
        DAT_O = '0;
        if (STB_I) begin
            if (ADR_I) begin
                DAT_O = {28'b0, r_ferr, r_ovr, r_rxvalid, r_txfull | w_txbusy};
            end else begin
                DAT_O = {24'b0, r_rxdata};
            end
        end
    end

    assign ACK_O = STB_I;

endmodule

// File: tb/tb_m_wbuart.sv
// Testbench for m_wbuart (DIVISOR=8). Bus reads and transmitted frames are
// checked by two monitors against queues filled by the stimulus process.
module tb_m_wbuart;

    localparam int unsigned D = 8;

    typedef struct {
        logic [7:0]  data;
        int unsigned start;
    } txexp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stb = 1'b0;
    logic        we = 1'b0;
    logic        adr = 1'b0;
    logic [7:0]  dat_i = 8'h00;
    logic [31:0] dat_o;
    logic        ack;
    logic        rx;
    logic        tx;
    logic        rx_drv = 1'b1;
    logic        loop = 1'b0;
    logic        tx_mon_en = 1'b1;

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;

    logic [31:0] rd_q[$];
    txexp_t      tx_q[$];

    assign rx = loop ? tx : rx_drv;

    m_wbuart #(.DIVISOR(D)) dut (
        .CLK_I   (clk),
        .RST_I   (rst_n),
        .STB_I   (stb),
        .WE_I    (we),
        .ADR_I   (adr),
        .DAT_I   (dat_i),
        .DAT_O   (dat_o),
        .ACK_O   (ack),
        .usartRX (rx),
        .usartTX (tx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive one bus cycle starting just after a rising edge; accepted at the next edge.
    task automatic bus_op(input logic w, input logic a, input logic [7:0] d);
        stb = 1'b1; we = w; adr = a; dat_i = d;
        @(posedge clk); #1;
        stb = 1'b0; we = 1'b0; adr = 1'b0; dat_i = 8'h00;
    endtask

    task automatic rd(input logic a, input logic [31:0] exp);
        rd_q.push_back(exp);
        bus_op(1'b0, a, 8'h00);
    endtask

    task automatic wr(input logic a, input logic [7:0] d);
        bus_op(1'b1, a, d);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_until(input int unsigned t);
        while (cyc < t) begin @(posedge clk); #1; end
    endtask

    // Drive an 8N1 frame onto the RX pin with a selectable stop bit level.
    task automatic send_rx(input logic [7:0] b, input logic stop);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx_drv = fr[i];
            idle(int'(D));
        end
        rx_drv = 1'b1;
    endtask

    // Bus read monitor
    always @(negedge clk) begin
        if (stb) begin
            chk("ack", 32'(ack), 32'(1));
            if (!we) begin
                chk("rd_expected", 32'(rd_q.size() != 0), 32'(1));
                if (rd_q.size() != 0) chk("rd_data", dat_o, rd_q.pop_front());
            end
        end else begin
            chk("dat_o_idle", dat_o, 32'(0));
        end
    end

    // Serial frame monitor: checks start cycle and the level of every bit cycle
    initial begin : tx_mon
        int unsigned s;
        logic [9:0]  fr;
        int          bad;
        txexp_t      e;
        wait (rst_n);
        @(negedge clk);
        forever begin
            if (tx_mon_en && tx === 1'b0) begin
                s = cyc;
                chk("tx_frame_expected", 32'(tx_q.size() != 0), 32'(1));
                if (tx_q.size() != 0) begin
                    e = tx_q.pop_front();
                end else begin
                    e.data = 8'h00;
                    e.start = s;
                end
                chk("tx_start_cycle", 32'(s), 32'(e.start));
                fr = {1'b1, e.data, 1'b0};
                bad = 0;
                for (int j = 0; j < int'(10 * D); j++) begin
                    if (!tx_mon_en) break;
                    if (tx !== fr[j / int'(D)]) bad++;
                    @(negedge clk);
                end
                chk("tx_wave", 32'(bad), 32'(0));
            end else begin
                @(negedge clk);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int unsigned c;

        // Reset
        repeat (3) begin
            @(negedge clk);
            chk("tx_in_reset", 32'(tx), 32'(1));
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(2);
        chk("tx_after_reset", 32'(tx), 32'(1));
        rd(1'b1, 32'h0);
        rd(1'b0, 32'h0);

        // Single frame 0x55 and busy timing
        c = cyc;
        tx_q.push_back('{8'h55, c + 2});
        wr(1'b0, 8'h55);
        rd(1'b1, 32'h1);
        wait_until(c + 1 + 80);
        rd(1'b1, 32'h1);
        rd(1'b1, 32'h0);
        idle(5);

        // Back-to-back frames; third write dropped while full
        c = cyc;
        tx_q.push_back('{8'hA3, c + 2});
        tx_q.push_back('{8'h0F, c + 2 + 80});
        wr(1'b0, 8'hA3);
        idle(1);
        wr(1'b0, 8'h0F);
        wr(1'b0, 8'hFF);
        rd(1'b1, 32'h1);
        wait_until(c + 2 + 200);
        chk("tx_q_drained", 32'(tx_q.size()), 32'(0));

        // Loopback single byte
        loop = 1'b1;
        c = cyc;
        tx_q.push_back('{8'hC4, c + 2});
        wr(1'b0, 8'hC4);
        wait_until(c + 2 + 90);
        rd(1'b1, 32'h2);
        rd(1'b0, 32'h0000_00C4);
        rd(1'b1, 32'h0);

        // Overrun: two bytes without a read
        c = cyc;
        tx_q.push_back('{8'h11, c + 2});
        tx_q.push_back('{8'h22, c + 2 + 80});
        wr(1'b0, 8'h11);
        idle(1);
        wr(1'b0, 8'h22);
        wait_until(c + 2 + 80 + 90);
        rd(1'b1, 32'h6);
        rd(1'b0, 32'h22);
        wr(1'b1, 8'h04);
        rd(1'b1, 32'h0);
        loop = 1'b0;
        idle(5);

        // Framing error: stop bit low
        send_rx(8'h7E, 1'b0);
        idle(20);
        rd(1'b1, 32'hA);
        rd(1'b0, 32'h7E);
        wr(1'b1, 8'h08);
        rd(1'b1, 32'h0);

        // Short glitch must not produce a byte; a following clean frame must
        rx_drv = 1'b0;
        idle(2);
        rx_drv = 1'b1;
        idle(30);
        rd(1'b1, 32'h0);
        send_rx(8'h3C, 1'b1);
        idle(20);
        rd(1'b1, 32'h2);
        rd(1'b0, 32'h3C);
        rd(1'b1, 32'h0);

        // Reset in the middle of a transmitted start bit
        tx_mon_en = 1'b0;
        wr(1'b0, 8'h99);
        idle(3);
        chk("tx_start_low", 32'(tx), 32'(0));
        #2;
        rst_n = 1'b0;
        #1;
        chk("tx_async_reset", 32'(tx), 32'(1));
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(2);
        rd(1'b1, 32'h0);
        chk("tx_idle_after_reset", 32'(tx), 32'(1));

        idle(5);
        chk("rd_q_empty", 32'(rd_q.size()), 32'(0));
        chk("tx_q_empty", 32'(tx_q.size()), 32'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
